status_stack: RTL and testbench

- LIFO that saves the processor status bits on subroutine call or interrupt entry, and restores them on return.
- On each pop it drives the status-register write interface for one cycle: restored value, write enable, and decoder-path select.
- Sits between the decoder/sequencer (issues push/pop) and the status register.
- Lets the status register be rewritten from saved context without ALU involvement.

---
 rtl/status_stack.sv | 141 ++++++++++++++
 tb/tb_status_stack.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/status_stack.sv
// status_stack: LIFO for processor status bits.
// Push saves the current status word on call/interrupt entry; pop restores the
// top word and strobes the status register write port for one cycle.
// Simultaneous push+pop on a non-empty stack swaps the top entry in place.
// Overflow/underflow are sticky until clear_err; a new error in the same cycle
// as clear_err keeps the flag set.
module status_stack #(
  parameter int NumStatusBits = 2,
  parameter int Depth         = 4,
  parameter int PtrWidth      = 2
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic [NumStatusBits-1:0] status,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear_err,
  output logic [NumStatusBits-1:0] restore_status,
  output logic                     restore_wr_en,
  output logic                     sel_stat_in_alu_decoder,
  output logic [PtrWidth:0]        level,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     underflow
);

  localparam logic [PtrWidth:0] LevelMax = (PtrWidth+1)'(Depth);
  localparam logic [PtrWidth:0] LevelOne = (PtrWidth+1)'(1);

  logic [NumStatusBits-1:0] mem [Depth];

  logic [PtrWidth:0]   level_m1;
  logic [PtrWidth-1:0] top_idx;
  logic [PtrWidth-1:0] wr_idx;
  logic                pop_ok;
  logic                mem_we;
  logic                level_inc;
  logic                level_dec;
  logic                ovf_evt;
  logic                unf_evt;

  assign full  = (level == LevelMax);
  assign empty = (level == '0);

  // Status source select is always the decoder path.
  assign sel_stat_in_alu_decoder = 1'b0;

  assign level_m1 = level - LevelOne;
  assign top_idx  = level_m1[PtrWidth-1:0];

  // Decode push/pop into memory write, pointer movement and error events.
  always_comb begin
    pop_ok    = 1'b0;
    mem_we    = 1'b0;
    wr_idx    = level[PtrWidth-1:0];
    level_inc = 1'b0;
    level_dec = 1'b0;
    ovf_evt   = 1'b0;
    unf_evt   = 1'b0;
    if (push && pop) begin
      if (empty) begin
        // Nothing to restore: the push goes ahead, the pop is an underflow.
        mem_we    = 1'b1;
        wr_idx    = '0;
        level_inc = 1'b1;
        unf_evt   = 1'b1;
      end else begin
        // Swap: read old top, overwrite it with current status.
        pop_ok = 1'b1;
        mem_we = 1'b1;
        wr_idx = top_idx;
      end
    end else if (push) begin
      if (full) begin
        ovf_evt = 1'b1;
      end else begin
        mem_we    = 1'b1;
        level_inc = 1'b1;
      end
    end else if (pop) begin
      if (empty) begin
        unf_evt = 1'b1;
      end else begin
        pop_ok    = 1'b1;
        level_dec = 1'b1;
      end
    end
  end

  // Stack storage; contents are meaningless after reset so no reset term.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_idx] <= status;
    end
  end

  // Stack pointer, saturating at 0 and Depth by construction of the decode.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      level <= '0;
    end else if (level_inc) begin
      level <= level + LevelOne;
    end else if (level_dec) begin
      level <= level_m1;
    end
  end

  // Restore data and its one-cycle write strobe to the status register.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      restore_status <= '0;
      restore_wr_en  <= 1'b0;
    end else begin
      restore_wr_en <= pop_ok;
      if (pop_ok) begin
        restore_status <= mem[top_idx];
      end
    end
  end

  // Sticky error flags; a new event wins over clear_err.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_evt) begin
        overflow <= 1'b1;
      end else if (clear_err) begin
        overflow <= 1'b0;
      end
      if (unf_evt) begin
        underflow <= 1'b1;
      end else if (clear_err) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_status_stack.sv
// Directed, table-driven bench for status_stack (Depth=4, 2 status bits).
module tb_status_stack;

  logic       clk;
  logic       res;
  logic [1:0] status;
  logic       push;
  logic       pop;
  logic       clear_err;
  logic [1:0] restore_status;
  logic       restore_wr_en;
  logic       sel_stat_in_alu_decoder;
  logic [2:0] level;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       underflow;

  int total = 0;
  int bad   = 0;

  status_stack #(
    .NumStatusBits(2),
    .Depth(4),
    .PtrWidth(2)
  ) dut (
    .clk(clk),
    .res(res),
    .status(status),
    .push(push),
    .pop(pop),
    .clear_err(clear_err),
    .restore_status(restore_status),
    .restore_wr_en(restore_wr_en),
    .sel_stat_in_alu_decoder(sel_stat_in_alu_decoder),
    .level(level),
    .full(full),
    .empty(empty),
    .overflow(overflow),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       res;
    logic [1:0] st;
    logic       push;
    logic       pop;
    logic       clr;
    logic [1:0] rs;
    logic       we;
    logic [2:0] lvl;
    logic       ovf;
    logic       unf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [1:0] st, input logic pu,
                     input logic po, input logic cl, input logic [1:0] rs,
                     input logic we, input logic [2:0] lvl, input logic ovf,
                     input logic unf);
    vec_t v;
    v.res = r; v.st = st; v.push = pu; v.pop = po; v.clr = cl;
    v.rs = rs; v.we = we; v.lvl = lvl; v.ovf = ovf; v.unf = unf;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s vec %0d: got %0h want %0h", name, idx, got, want);
    end
  endtask

  task automatic check_vec(input int i, input vec_t v);
    check("restore_status", i, 8'(restore_status), 8'(v.rs));
    check("restore_wr_en", i, 8'(restore_wr_en), 8'(v.we));
    check("level", i, 8'(level), 8'(v.lvl));
    check("full", i, 8'(full), 8'(v.lvl == 3'd4));
    check("empty", i, 8'(empty), 8'(v.lvl == 3'd0));
    check("overflow", i, 8'(overflow), 8'(v.ovf));
    check("underflow", i, 8'(underflow), 8'(v.unf));
    check("sel_stat", i, 8'(sel_stat_in_alu_decoder), 8'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //  res st    pu po cl | rs    we lvl   ovf unf
    add(1, 2'b00, 0, 0, 0,  2'b00, 0, 3'd0, 0, 0);  // 0 reset
    add(0, 2'b00, 0, 0, 0,  2'b00, 0, 3'd0, 0, 0);  // 1 idle
    add(0, 2'b00, 0, 0, 0,  2'b00, 0, 3'd0, 0, 0);  // 2 idle
    add(0, 2'b00, 0, 0, 0,  2'b00, 0, 3'd0, 0, 0);  // 3 idle
    add(0, 2'b01, 1, 0, 0,  2'b00, 0, 3'd1, 0, 0);  // 4 push 01
    add(0, 2'b10, 1, 0, 0,  2'b00, 0, 3'd2, 0, 0);  // 5 push 10
    add(0, 2'b11, 1, 0, 0,  2'b00, 0, 3'd3, 0, 0);  // 6 push 11
    add(0, 2'b00, 0, 1, 0,  2'b11, 1, 3'd2, 0, 0);  // 7 pop
    add(0, 2'b00, 0, 1, 0,  2'b10, 1, 3'd1, 0, 0);  // 8 pop
    add(0, 2'b00, 0, 1, 0,  2'b01, 1, 3'd0, 0, 0);  // 9 pop
    add(0, 2'b00, 0, 0, 0,  2'b01, 0, 3'd0, 0, 0);  // 10 idle, value held
    add(0, 2'b00, 1, 0, 0,  2'b01, 0, 3'd1, 0, 0);  // 11 push 00
    add(0, 2'b01, 1, 0, 0,  2'b01, 0, 3'd2, 0, 0);  // 12 push 01
    add(0, 2'b10, 1, 0, 0,  2'b01, 0, 3'd3, 0, 0);  // 13 push 10
    add(0, 2'b11, 1, 0, 0,  2'b01, 0, 3'd4, 0, 0);  // 14 push 11 -> full
    add(0, 2'b01, 1, 0, 0,  2'b01, 0, 3'd4, 1, 0);  // 15 push while full
    add(0, 2'b00, 0, 1, 0,  2'b11, 1, 3'd3, 1, 0);  // 16 pop -> 11
    add(0, 2'b00, 0, 0, 1,  2'b11, 0, 3'd3, 0, 0);  // 17 clear_err
    add(1, 2'b00, 0, 0, 0,  2'b00, 0, 3'd0, 0, 0);  // 18 reset
    add(0, 2'b00, 0, 1, 0,  2'b00, 0, 3'd0, 0, 1);  // 19 pop empty
    add(0, 2'b00, 0, 0, 1,  2'b00, 0, 3'd0, 0, 0);  // 20 clear_err
    add(0, 2'b00, 0, 1, 0,  2'b00, 0, 3'd0, 0, 1);  // 21 pop empty
    add(0, 2'b00, 0, 1, 1,  2'b00, 0, 3'd0, 0, 1);  // 22 pop empty + clear: set wins
    add(0, 2'b00, 0, 0, 1,  2'b00, 0, 3'd0, 0, 0);  // 23 clear_err
    add(0, 2'b01, 1, 0, 0,  2'b00, 0, 3'd1, 0, 0);  // 24 push 01
    add(0, 2'b10, 1, 0, 0,  2'b00, 0, 3'd2, 0, 0);  // 25 push 10
    add(0, 2'b01, 1, 1, 0,  2'b10, 1, 3'd2, 0, 0);  // 26 swap in 01
    add(0, 2'b00, 0, 1, 0,  2'b01, 1, 3'd1, 0, 0);  // 27 pop -> 01 (swapped)
    add(0, 2'b00, 0, 1, 0,  2'b01, 1, 3'd0, 0, 0);  // 28 pop -> 01 (bottom)
    add(0, 2'b11, 1, 1, 0,  2'b01, 0, 3'd1, 0, 1);  // 29 push+pop empty
    add(0, 2'b00, 0, 1, 0,  2'b11, 1, 3'd0, 0, 1);  // 30 pop -> 11
    add(0, 2'b00, 0, 0, 1,  2'b11, 0, 3'd0, 0, 0);  // 31 clear_err
    add(0, 2'b00, 1, 0, 0,  2'b11, 0, 3'd1, 0, 0);  // 32 push 00
    add(0, 2'b01, 1, 0, 0,  2'b11, 0, 3'd2, 0, 0);  // 33 push 01
    add(0, 2'b10, 1, 0, 0,  2'b11, 0, 3'd3, 0, 0);  // 34 push 10
    add(0, 2'b11, 1, 0, 0,  2'b11, 0, 3'd4, 0, 0);  // 35 push 11 -> full
    add(0, 2'b10, 1, 1, 0,  2'b11, 1, 3'd4, 0, 0);  // 36 swap while full, no ovf
    add(0, 2'b00, 0, 1, 0,  2'b10, 1, 3'd3, 0, 0);  // 37 pop -> 10
    add(0, 2'b00, 0, 1, 0,  2'b10, 1, 3'd2, 0, 0);  // 38 pop -> 10 (mem[2])
    add(0, 2'b00, 0, 0, 0,  2'b10, 0, 3'd2, 0, 0);  // 39 idle

    for (int i = 0; i < vecs.size(); i++) begin
      res       = vecs[i].res;
      status    = vecs[i].st;
      push      = vecs[i].push;
      pop       = vecs[i].pop;
      clear_err = vecs[i].clr;
      @(posedge clk);
      #1;
      check_vec(i, vecs[i]);
    end

    // Reset arriving while a restore strobe is pending cancels it at once.
    res = 1'b1; push = 1'b0; pop = 1'b0; clear_err = 1'b0; status = 2'b00;
    @(posedge clk); #1;
    res = 1'b0; push = 1'b1; status = 2'b11;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b1;
    @(posedge clk); #1;
    pop = 1'b0;
    check("rst_mid we_before", 100, 8'(restore_wr_en), 8'd1);
    check("rst_mid rs_before", 100, 8'(restore_status), 8'd3);
    #2;
    res = 1'b1;
    #1;
    check("rst_mid we", 101, 8'(restore_wr_en), 8'd0);
    check("rst_mid level", 101, 8'(level), 8'd0);
    check("rst_mid rs", 101, 8'(restore_status), 8'd0);
    check("rst_mid empty", 101, 8'(empty), 8'd1);
    @(posedge clk); #1;
    res = 1'b0;
    @(posedge clk); #1;
    check("post_rst we", 102, 8'(restore_wr_en), 8'd0);
    check("post_rst level", 102, 8'(level), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
